fb_rd_timing_gen: RTL and testbench

- Video timing generator and FIFO read pacer for the frame-buffer read path.
- Builds VS/HS/DE raster timing in port-clock units (C_PORT_NUM pixels per clock). Pops DDR read data from a FWFT FIFO during active video.
- Drives the pixel timing and data inputs of the downstream colour-space-conversion stage.
- For YUV420 it asserts PIXEL_DE_O only on even active lines. PIXEL_DE_TOTAL_O covers every active line, so the downstream stage replays the buffered line.

---
 rtl/fb_rd_timing_gen_pkg.sv | 22 ++
 rtl/fb_rd_timing_gen_axis_cnt.sv | 46 ++++
 rtl/fb_rd_timing_gen.sv | 144 ++++++++++++++
 tb/tb_fb_rd_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_rd_timing_gen_pkg.sv
// Shared definitions for the frame-buffer read timing generator:
// colour-space codes, controller states and the YUV420 line-skip rule.
package fb_rd_timing_gen_pkg;

    typedef enum logic [3:0] {
        CS_RGB    = 4'd0,
        CS_YUV444 = 4'd1,
        CS_YUV422 = 4'd2,
        CS_YUV420 = 4'd3
    } cspace_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tg_state_e;

    // YUV420 fetches chroma-bearing data only on even active lines.
    function automatic logic skip_line(input logic [3:0] ispace, input logic aline_odd);
        return (ispace == CS_YUV420) && aline_odd;
    endfunction

endpackage

// File: rtl/fb_rd_timing_gen_axis_cnt.sv
// One raster axis: sync/back-porch/active/front-porch counter with wrap
// and region decode. Used once for H and once for V (advancing on H wrap).
module tg_axis_cnt #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] sync,
    input  logic [W-1:0] bp,
    input  logic [W-1:0] active,
    input  logic [W-1:0] fp,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         in_sync,
    output logic         in_act
);

    // Two extra bits so the summed totals cannot wrap.
    localparam int XW = W + 2;

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] act_start;
    logic [XW-1:0] act_end;
    logic [XW-1:0] total;

    assign cnt_x     = {2'b00, cnt};
    assign act_start = {2'b00, sync} + {2'b00, bp};
    assign act_end   = act_start + {2'b00, active};
    assign total     = act_end + {2'b00, fp};

    assign last    = (cnt_x == total - XW'(1));
    assign in_sync = (cnt < sync);
    assign in_act  = (cnt_x >= act_start) && (cnt_x < act_end);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/fb_rd_timing_gen.sv
// Frame-buffer read timing generator: builds VS/HS/DE raster timing in
// port-clock units and pops a FWFT FIFO during active video.
module fb_rd_timing_gen
    import fb_rd_timing_gen_pkg::*;
#(
    parameter int C_PORT_NUM = 4,
    parameter int C_BPC      = 8,
    parameter int C_HW       = 13,
    parameter int C_VW       = 12
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic                          ENABLE_I,
    input  logic [3:0]                    ISPACE_I,
    input  logic [C_HW-1:0]               H_SYNC_I,
    input  logic [C_HW-1:0]               H_BP_I,
    input  logic [C_HW-1:0]               H_ACTIVE_I,
    input  logic [C_HW-1:0]               H_FP_I,
    input  logic [C_VW-1:0]               V_SYNC_I,
    input  logic [C_VW-1:0]               V_BP_I,
    input  logic [C_VW-1:0]               V_ACTIVE_I,
    input  logic [C_VW-1:0]               V_FP_I,
    input  logic [C_BPC*3*C_PORT_NUM-1:0] FIFO_DATA_I,
    input  logic                          FIFO_EMPTY_I,
    output logic                          FIFO_RD_EN_O,
    output logic                          PIXEL_VS_O,
    output logic                          PIXEL_HS_O,
    output logic                          PIXEL_DE_O,
    output logic                          PIXEL_DE_TOTAL_O,
    output logic [C_BPC*3*C_PORT_NUM-1:0] PIXEL_DATA_O,
    output logic                          FRAME_START_O,
    output logic                          UNDERFLOW_O,
    output logic                          BUSY_O
);

    tg_state_e       state;
    logic [3:0]      ispace_q;
    logic [C_HW-1:0] h_sync_q, h_bp_q, h_active_q, h_fp_q;
    logic [C_VW-1:0] v_sync_q, v_bp_q, v_active_q, v_fp_q;

    logic [C_HW-1:0] hcnt;
    logic [C_VW-1:0] vcnt;
    logic            h_last, v_last, h_sync, v_sync, h_act, v_act;
    logic            run, start, boundary, load;
    logic            aline_odd, de_total, de;

    assign run      = (state == ST_RUN);
    assign start    = (state == ST_IDLE) && ENABLE_I;
    assign boundary = run && h_last && v_last;
    assign load     = start || boundary;

    tg_axis_cnt #(.W(C_HW)) u_h_cnt (
        .clk     (CLK_I),
        .rst     (RST_I),
        .clr     (!run),
        .adv     (run),
        .sync    (h_sync_q),
        .bp      (h_bp_q),
        .active  (h_active_q),
        .fp      (h_fp_q),
        .cnt     (hcnt),
        .last    (h_last),
        .in_sync (h_sync),
        .in_act  (h_act)
    );

    tg_axis_cnt #(.W(C_VW)) u_v_cnt (
        .clk     (CLK_I),
        .rst     (RST_I),
        .clr     (!run),
        .adv     (run && h_last),
        .sync    (v_sync_q),
        .bp      (v_bp_q),
        .active  (v_active_q),
        .fp      (v_fp_q),
        .cnt     (vcnt),
        .last    (v_last),
        .in_sync (v_sync),
        .in_act  (v_act)
    );

    // Parity of (vcnt - active_start) without a subtractor.
    assign aline_odd = vcnt[0] ^ v_sync_q[0] ^ v_bp_q[0];
    assign de_total  = run && h_act && v_act;
    assign de        = de_total && !skip_line(ispace_q, aline_odd);

    // NOTE: the pop is combinational so the FWFT head word and the pop land on the same edge.
    assign FIFO_RD_EN_O = de && !FIFO_EMPTY_I;
    assign BUSY_O       = run;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state            <= ST_IDLE;
            ispace_q         <= '0;
            h_sync_q         <= '0;
            h_bp_q           <= '0;
            h_active_q       <= '0;
            h_fp_q           <= '0;
            v_sync_q         <= '0;
            v_bp_q           <= '0;
            v_active_q       <= '0;
            v_fp_q           <= '0;
            PIXEL_VS_O       <= 1'b0;
            PIXEL_HS_O       <= 1'b0;
            PIXEL_DE_O       <= 1'b0;
            PIXEL_DE_TOTAL_O <= 1'b0;
            PIXEL_DATA_O     <= '0;
            FRAME_START_O    <= 1'b0;
            UNDERFLOW_O      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (ENABLE_I) state <= ST_RUN;
                ST_RUN:  if (boundary && !ENABLE_I) state <= ST_IDLE;
            endcase

            if (load) begin
                ispace_q   <= ISPACE_I;
                h_sync_q   <= H_SYNC_I;
                h_bp_q     <= H_BP_I;
                h_active_q <= H_ACTIVE_I;
                h_fp_q     <= H_FP_I;
                v_sync_q   <= V_SYNC_I;
                v_bp_q     <= V_BP_I;
                v_active_q <= V_ACTIVE_I;
                v_fp_q     <= V_FP_I;
            end

            if (start) begin
                UNDERFLOW_O <= 1'b0;
            end else if (de && FIFO_EMPTY_I) begin
                UNDERFLOW_O <= 1'b1;
            end

            // Timing is never stalled; a missing word goes out as zero.
            PIXEL_VS_O       <= run && v_sync;
            PIXEL_HS_O       <= run && h_sync;
            PIXEL_DE_O       <= de;
            PIXEL_DE_TOTAL_O <= de_total;
            PIXEL_DATA_O     <= (de && !FIFO_EMPTY_I) ? FIFO_DATA_I : '0;
            FRAME_START_O    <= run && (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_fb_rd_timing_gen.sv
// Randomised bench for fb_rd_timing_gen against a frame-position model
// (position t inside the frame, h = t % HTOT, v = t / HTOT).
module tb_fb_rd_timing_gen;

    localparam int PN = 4;
    localparam int BPC = 8;
    localparam int HW = 13;
    localparam int VW = 12;
    localparam int DW = BPC * 3 * PN;

    logic          CLK_I = 1'b0;
    logic          RST_I, ENABLE_I, FIFO_EMPTY_I;
    logic [3:0]    ISPACE_I;
    logic [HW-1:0] H_SYNC_I, H_BP_I, H_ACTIVE_I, H_FP_I;
    logic [VW-1:0] V_SYNC_I, V_BP_I, V_ACTIVE_I, V_FP_I;
    logic [DW-1:0] FIFO_DATA_I, PIXEL_DATA_O;
    logic          FIFO_RD_EN_O, PIXEL_VS_O, PIXEL_HS_O, PIXEL_DE_O, PIXEL_DE_TOTAL_O;
    logic          FRAME_START_O, UNDERFLOW_O, BUSY_O;

    fb_rd_timing_gen #(.C_PORT_NUM(PN), .C_BPC(BPC), .C_HW(HW), .C_VW(VW)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ENABLE_I(ENABLE_I), .ISPACE_I(ISPACE_I),
        .H_SYNC_I(H_SYNC_I), .H_BP_I(H_BP_I), .H_ACTIVE_I(H_ACTIVE_I), .H_FP_I(H_FP_I),
        .V_SYNC_I(V_SYNC_I), .V_BP_I(V_BP_I), .V_ACTIVE_I(V_ACTIVE_I), .V_FP_I(V_FP_I),
        .FIFO_DATA_I(FIFO_DATA_I), .FIFO_EMPTY_I(FIFO_EMPTY_I), .FIFO_RD_EN_O(FIFO_RD_EN_O),
        .PIXEL_VS_O(PIXEL_VS_O), .PIXEL_HS_O(PIXEL_HS_O), .PIXEL_DE_O(PIXEL_DE_O),
        .PIXEL_DE_TOTAL_O(PIXEL_DE_TOTAL_O), .PIXEL_DATA_O(PIXEL_DATA_O),
        .FRAME_START_O(FRAME_START_O), .UNDERFLOW_O(UNDERFLOW_O), .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i);
        logic [31:0] u;
        u = i;
        return {u * 32'h9E3779B1, ~u, u + 32'h5A5A0000};
    endfunction

    // FWFT FIFO environment: head word is a function of how many pops it saw.
    int env_idx = 0;
    assign FIFO_DATA_I = word(env_idx);

    // Reference model state.
    bit m_run = 0;
    int m_t = 0;
    int m_hs, m_hbp, m_ha, m_hfp, m_vs, m_vbp, m_va, m_vfp, m_isp;
    bit m_ufl = 0;
    bit m_de = 0;
    int exp_idx = 0;

    logic          e_vs, e_hs, e_de, e_det, e_fs, e_busy, e_ufl;
    logic [DW-1:0] e_data;

    int n_pop, n_fs, n_de, n_det;

    task automatic latch_model();
        m_hs = int'(H_SYNC_I);  m_hbp = int'(H_BP_I);  m_ha = int'(H_ACTIVE_I);  m_hfp = int'(H_FP_I);
        m_vs = int'(V_SYNC_I);  m_vbp = int'(V_BP_I);  m_va = int'(V_ACTIVE_I);  m_vfp = int'(V_FP_I);
        m_isp = int'(ISPACE_I);
    endtask

    task automatic step();
        int htot, vtot, h, v, ha0, va0;
        bit hs, vs, det, pop, rd_obs;
        @(negedge CLK_I);
        htot = m_hs + m_hbp + m_ha + m_hfp;
        vtot = m_vs + m_vbp + m_va + m_vfp;
        hs = 0; vs = 0; det = 0; m_de = 0;
        if (m_run) begin
            h = m_t % htot;
            v = m_t / htot;
            ha0 = m_hs + m_hbp;
            va0 = m_vs + m_vbp;
            hs = h < m_hs;
            vs = v < m_vs;
            det = (h >= ha0) && (h < ha0 + m_ha) && (v >= va0) && (v < va0 + m_va);
            m_de = det && (m_isp != 3 || ((v - va0) % 2) == 0);
        end
        pop = m_de && !FIFO_EMPTY_I;
        check("rd_en", FIFO_RD_EN_O, pop);
        rd_obs = FIFO_RD_EN_O;

        if (RST_I) begin
            {e_vs, e_hs, e_de, e_det, e_fs} = '0;
            e_data = '0;
        end else begin
            e_vs = vs; e_hs = hs; e_de = m_de; e_det = det;
            e_data = pop ? word(exp_idx) : '0;
            e_fs = m_run && m_t == 0;
        end
        if (pop) exp_idx++;

        if (RST_I) begin
            m_run = 0; m_t = 0; m_ufl = 0;
        end else if (!m_run) begin
            if (ENABLE_I) begin
                m_run = 1; m_t = 0; m_ufl = 0;
                latch_model();
            end
        end else begin
            if (m_de && FIFO_EMPTY_I) m_ufl = 1;
            if (m_t == htot * vtot - 1) begin
                m_t = 0;
                latch_model();
                if (!ENABLE_I) m_run = 0;
            end else begin
                m_t++;
            end
        end
        e_busy = m_run;
        e_ufl = m_ufl;

        @(posedge CLK_I);
        #1;
        if (rd_obs && !FIFO_EMPTY_I) env_idx++;
        check("vs", PIXEL_VS_O, e_vs);
        check("hs", PIXEL_HS_O, e_hs);
        check("de", PIXEL_DE_O, e_de);
        check("de_total", PIXEL_DE_TOTAL_O, e_det);
        check("data", PIXEL_DATA_O, e_data);
        check("frame_start", FRAME_START_O, e_fs);
        check("busy", BUSY_O, e_busy);
        check("underflow", UNDERFLOW_O, e_ufl);
        n_pop += int'(rd_obs);
        n_fs  += int'(FRAME_START_O);
        n_de  += int'(PIXEL_DE_O);
        n_det += int'(PIXEL_DE_TOTAL_O);
    endtask

    task automatic run_n(input int n);
        repeat (n) step();
    endtask

    task automatic clr_counts();
        n_pop = 0; n_fs = 0; n_de = 0; n_det = 0;
    endtask

    task automatic set_timing(input int hs, input int hbp, input int ha, input int hfp,
                              input int vs, input int vbp, input int va, input int vfp);
        H_SYNC_I = HW'(hs); H_BP_I = HW'(hbp); H_ACTIVE_I = HW'(ha); H_FP_I = HW'(hfp);
        V_SYNC_I = VW'(vs); V_BP_I = VW'(vbp); V_ACTIVE_I = VW'(va); V_FP_I = VW'(vfp);
    endtask

    task automatic wait_model_de(input string tag);
        int i;
        for (i = 0; i < 400 && !m_de; i++) step();
        check(tag, 1'(m_de), 1'b1);
    endtask

    initial begin
        int i;
        RST_I = 1; ENABLE_I = 0; FIFO_EMPTY_I = 0; ISPACE_I = 4'd0;
        set_timing(2, 2, 8, 2, 1, 1, 4, 1);
        run_n(3);
        check("reset_busy", BUSY_O, 1'b0);
        check("reset_data", PIXEL_DATA_O, '0);

        // Basic RGB raster: 14 x 7 = 98 clocks per frame.
        RST_I = 0; ENABLE_I = 1;
        run_n(98);
        clr_counts();
        run_n(98);
        check("rgb_pops", n_pop, 32);
        check("rgb_de", n_de, 32);
        check("rgb_de_total", n_det, 32);
        check("rgb_frame_start", n_fs, 1);

        // YUV420: DE only on even active lines.
        ISPACE_I = 4'd3;
        run_n(98);
        clr_counts();
        run_n(98);
        check("yuv420_pops", n_pop, 16);
        check("yuv420_de", n_de, 16);
        check("yuv420_de_total", n_det, 32);

        // Underflow: three empty clocks mid-line.
        ISPACE_I = 4'd0;
        run_n(98);
        wait_model_de("ufl_find_de");
        step();
        FIFO_EMPTY_I = 1;
        run_n(3);
        FIFO_EMPTY_I = 0;
        run_n(98);
        check("ufl_sticky", UNDERFLOW_O, 1'b1);

        // Enable drop mid-frame: frame completes, then idle.
        for (i = 0; i < 200 && m_t != 40; i++) step();
        ENABLE_I = 0;
        for (i = 0; i < 200 && BUSY_O; i++) step();
        check("busy_fall", BUSY_O, 1'b0);
        run_n(3);
        ENABLE_I = 1;
        run_n(2);
        check("ufl_cleared", UNDERFLOW_O, 1'b0);

        // Mid-frame timing change takes effect at the next frame (84 clocks).
        for (i = 0; i < 200 && m_t != 20; i++) step();
        set_timing(2, 2, 6, 2, 1, 1, 4, 1);
        run_n(200);
        clr_counts();
        run_n(84);
        check("hact6_de", n_de, 24);
        check("hact6_frame_start", n_fs, 1);

        // Reset while DE is high.
        set_timing(2, 2, 8, 2, 1, 1, 4, 1);
        run_n(84);
        wait_model_de("rst_find_de");
        RST_I = 1;
        step();
        RST_I = 0; ENABLE_I = 0;
        run_n(4);
        check("rst_idle", BUSY_O, 1'b0);
        ENABLE_I = 1;

        // Randomised timings, colour space, FIFO empties and enable drops.
        for (int it = 0; it < 8; it++) begin
            set_timing($urandom_range(3, 1), $urandom_range(3, 0), $urandom_range(6, 0), $urandom_range(3, 1),
                       $urandom_range(2, 1), $urandom_range(2, 0), $urandom_range(4, 0), $urandom_range(2, 1));
            ISPACE_I = 4'($urandom_range(3, 0));
            repeat (300) begin
                FIFO_EMPTY_I = ($urandom_range(7, 0) == 0);
                ENABLE_I = ($urandom_range(99, 0) != 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
